// File: rtl/storage_write_ctrl.sv
// storage_write_ctrl
//   Buffers upstream bytes in a small FIFO and writes each one into an 8-bit
//   storage register, then reads it back to confirm it stuck. A byte whose
//   readback fails is rewritten up to MAX_RETRY more times; after that it is
//   dropped and the sticky err flag is raised.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_n_i        asynchronous active-low reset
//   in_valid_i     upstream byte valid
//   in_data_i      upstream byte
//   in_ready_o     FIFO can accept a byte this cycle (registered state only)
//   wr_en_o        write strobe to the storage register
//   wr_data_o      data to the storage register
//   rd_data_i      readback from the storage register
//   err_clr_i      synchronous clear of err_o
//   busy_o         FSM not idle, or FIFO non-empty
//   done_pulse_o   one-cycle pulse per byte verified in storage
//   err_o          sticky: a byte was dropped after exhausting retries
//   fifo_count_o   FIFO occupancy, 0..DEPTH
module storage_write_ctrl #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       wr_en_o,
    output logic [7:0] wr_data_o,
    input  logic [7:0] rd_data_i,
    input  logic       err_clr_i,
    output logic       busy_o,
    output logic       done_pulse_o,
    output logic       err_o,
    output logic [3:0] fifo_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [3:0]    DEPTH_C     = 4'(DEPTH);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        VERIFY
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic [7:0]    hold_q, hold_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          push, pop, drop;

    always_comb begin
        push     = in_valid_i && (count_q < DEPTH_C);
        pop      = (state_q == IDLE) && (count_q != '0);
        drop     = 1'b0;
        state_d  = state_q;
        hold_d   = hold_q;
        retry_d  = retry_q;
        done_d   = 1'b0;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    hold_d  = mem_q[rd_ptr_q];
                    retry_d = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                if (rd_data_i == hold_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < MAX_RETRY_C) begin
                    retry_d = retry_q + 1'b1;
                    state_d = WRITE;
                end else begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A drop on the same edge as err_clr leaves err set.
        if (drop) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end

        // Power-of-two depth: pointers wrap by natural overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            retry_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            retry_q  <= retry_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Storage array needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    // hold_q only changes on the pop edge that enters WRITE, so it doubles as
    // wr_data and keeps its last driven value whenever wr_en is low.
    assign in_ready_o   = (count_q < DEPTH_C);
    assign wr_en_o      = (state_q == WRITE);
    assign wr_data_o    = hold_q;
    assign busy_o       = (state_q != IDLE) || (count_q != '0);
    assign done_pulse_o = done_q;
    assign err_o        = err_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_storage_write_ctrl.sv
module tb_storage_write_ctrl;

    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 2;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       err_clr = 1'b0;
    logic       busy;
    logic       done_pulse;
    logic       err;
    logic [3:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    storage_write_ctrl #(
        .DEPTH    (DEPTH),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .wr_en_o     (wr_en),
        .wr_data_o   (wr_data),
        .rd_data_i   (rd_data),
        .err_clr_i   (err_clr),
        .busy_o      (busy),
        .done_pulse_o(done_pulse),
        .err_o       (err),
        .fifo_count_o(fifo_count)
    );

    always #5 clk = ~clk;

    // Write corruption: every write, or only the write with a given index.
    logic corrupt_all = 1'b0;
    int   corrupt_idx = -1;

    // Storage register emulation plus output logs.
    logic [7:0] storage = 8'h00;
    int         env_wcnt = 0;
    bq_t        wlog;
    int         done_cnt = 0;
    int         peak = 0;

    assign rd_data = storage;

    always @(posedge clk) begin
        if (wr_en) begin
            storage  <= (corrupt_all || env_wcnt == corrupt_idx) ? ~wr_data : wr_data;
            env_wcnt <= env_wcnt + 1;
            wlog.push_back(wr_data);
        end
        if (done_pulse) done_cnt++;
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end

    // Behavioural model: a queue of pending bytes and one active byte whose
    // age counts cycles since it was popped; even ages are write cycles, odd
    // ages are readback cycles. Attempt n is verified at age 2n+1.
    logic [7:0] mq[$];
    logic       m_active = 1'b0;
    int         m_age = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_wd = 8'h00;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_storage = 8'h00;
    int         m_wcnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_active = 1'b0;
            m_age    = 0;
            m_cur    = 8'h00;
            m_wd     = 8'h00;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end else begin
            logic pre_ready;
            logic dropped;
            pre_ready = (mq.size() < DEPTH);
            dropped   = 1'b0;
            m_done    = 1'b0;
            if (m_active) begin
                if (m_age % 2 == 0) begin
                    m_storage = (corrupt_all || m_wcnt == corrupt_idx) ? ~m_cur : m_cur;
                    m_wcnt++;
                    m_age++;
                end else if (m_storage == m_cur) begin
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end else if (m_age / 2 < MAX_RETRY) begin
                    m_age++;
                end else begin
                    dropped  = 1'b1;
                    m_active = 1'b0;
                end
            end else if (mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_wd     = m_cur;
                m_active = 1'b1;
                m_age    = 0;
            end
            if (in_valid && pre_ready) mq.push_back(in_data);
            if (dropped) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_wr_en",    {31'b0, wr_en},      {31'b0, m_active && (m_age % 2 == 0)});
        chk("m_wr_data",  {24'b0, wr_data},    {24'b0, m_wd});
        chk("m_done",     {31'b0, done_pulse}, {31'b0, m_done});
        chk("m_err",      {31'b0, err},        {31'b0, m_err});
        chk("m_count",    {28'b0, fifo_count}, 32'(mq.size()));
        chk("m_in_ready", {31'b0, in_ready},   {31'b0, mq.size() < DEPTH});
        chk("m_busy",     {31'b0, busy},       {31'b0, m_active || mq.size() != 0});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) begin
                offer(d);
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        chk("push_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic chk_log(input string nm, input bq_t e);
        chk({nm, "_len"}, 32'(wlog.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < wlog.size(); i++) begin
            chk(nm, {24'b0, wlog[i]}, {24'b0, e[i]});
        end
    endtask

    initial begin
        bq_t exp_q;
        int  d0;
        int  w0;

        // Reset state
        tick(); tick();
        chk("rst_count", {28'b0, fifo_count}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_wdata", {24'b0, wr_data}, 32'h00);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_err",   {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte latency
        wlog.delete();
        d0 = done_cnt;
        offer(8'h55);
        chk("t1_count_k",  {28'b0, fifo_count}, 32'd1);
        tick();
        chk("t1_wr_en_k1", {31'b0, wr_en}, 32'd1);
        chk("t1_wdata_k1", {24'b0, wr_data}, 32'h55);
        chk("t1_model_wd", {24'b0, m_wd}, 32'h55);
        tick();
        chk("t1_wr_en_k2", {31'b0, wr_en}, 32'd0);
        tick();
        chk("t1_done_k3",  {31'b0, done_pulse}, 32'd1);
        tick();
        chk("t1_done_k4",  {31'b0, done_pulse}, 32'd0);
        chk("t1_err",      {31'b0, err}, 32'd0);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        exp_q = '{8'h55};
        chk_log("t1_log", exp_q);

        // Back-to-back bytes
        wlog.delete();
        d0 = done_cnt;
        peak = 0;
        offer(8'h55); offer(8'hAA); offer(8'hFF);
        for (int i = 0; i < 12; i++) tick();
        exp_q = '{8'h55, 8'hAA, 8'hFF};
        chk_log("t2_log", exp_q);
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd3);
        chk("t2_peak", 32'(peak), 32'd2);

        // Forced mismatch: fill, overflow attempt, retries and drops
        wlog.delete();
        d0 = done_cnt;
        corrupt_all = 1'b1;
        offer(8'h10); offer(8'h11); offer(8'h12); offer(8'h13); offer(8'h14);
        chk("t3_count_full", {28'b0, fifo_count}, 32'd4);
        chk("t3_ready_full", {31'b0, in_ready}, 32'd0);
        offer(8'h15);
        chk("t3_count_rej",  {28'b0, fifo_count}, 32'd4);
        tick();
        chk("t3_err_before", {31'b0, err}, 32'd0);
        tick();
        chk("t3_err_first",  {31'b0, err}, 32'd1);
        for (int i = 0; i < 35; i++) tick();
        exp_q.delete();
        for (int b = 8'h10; b <= 8'h14; b++) begin
            for (int r = 0; r <= MAX_RETRY; r++) exp_q.push_back(8'(b));
        end
        chk_log("t3_log", exp_q);
        chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t3_err_sticky", {31'b0, err}, 32'd1);
        corrupt_all = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_err_clr", {31'b0, err}, 32'd0);

        // One mismatch then match
        wlog.delete();
        d0 = done_cnt;
        corrupt_idx = env_wcnt;
        offer(8'hAA);
        for (int i = 0; i < 10; i++) tick();
        corrupt_idx = -1;
        exp_q = '{8'hAA, 8'hAA};
        chk_log("t4_log", exp_q);
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t4_err", {31'b0, err}, 32'd0);

        // Push+pop at count 3, then wrap-around over 12 bytes
        wlog.delete();
        d0 = done_cnt;
        offer(8'h20); offer(8'h21); offer(8'h22); offer(8'h23);
        chk("t5_count3", {28'b0, fifo_count}, 32'd3);
        offer(8'h24);
        chk("t5_pushpop", {28'b0, fifo_count}, 32'd3);
        for (int b = 8'h25; b <= 8'h2B; b++) push_byte(8'(b));
        for (int i = 0; i < 25; i++) tick();
        exp_q.delete();
        for (int b = 8'h20; b <= 8'h2B; b++) exp_q.push_back(8'(b));
        chk_log("t5_log", exp_q);
        chk("t5_done_cnt", 32'(done_cnt - d0), 32'd12);

        // Reset during VERIFY with two bytes queued
        wlog.delete();
        d0 = done_cnt;
        offer(8'h31); offer(8'h32); offer(8'h33);
        chk("t6_count_pre", {28'b0, fifo_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_wr_en",  {31'b0, wr_en}, 32'd0);
        chk("t6_wdata",  {24'b0, wr_data}, 32'h00);
        chk("t6_count",  {28'b0, fifo_count}, 32'd0);
        chk("t6_ready",  {31'b0, in_ready}, 32'd1);
        chk("t6_busy",   {31'b0, busy}, 32'd0);
        chk("t6_done",   {31'b0, done_pulse}, 32'd0);
        chk("t6_err",    {31'b0, err}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        w0 = wlog.size();
        for (int i = 0; i < 8; i++) tick();
        chk("t6_no_writes", 32'(wlog.size()), 32'(w0));
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t6_idle", {31'b0, busy}, 32'd0);
        offer(8'h44);
        for (int i = 0; i < 6; i++) tick();
        exp_q = '{8'h31, 8'h44};
        chk_log("t6_log", exp_q);
        chk("t6_done_after", 32'(done_cnt - d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
